variable_latency_cla: RTL and testbench



---
 rtl/variable_latency_cla.sv | 176 +++++++++++++++++
 tb/tb_variable_latency_cla.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/variable_latency_cla.sv
// Variable-latency carry-lookahead adder: speculative sum with a one-block carry
// window, mismatch detection, and an optional one-cycle correction to the exact sum.
module variable_latency_cla #(
    parameter int SIZE    = 16,
    parameter int VALENCY = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE:1]    a,
    input  logic [SIZE:1]    b,
    input  logic             cin,
    input  logic             approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SIZE:1]    sum,
    output logic             cout,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int NB = SIZE / VALENCY;

    generate
        if ((SIZE % VALENCY) != 0 || NB < 2) begin : g_param_check
            $error("variable_latency_cla: SIZE must be a multiple of VALENCY giving at least two blocks");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, EVAL, CORR, HOLD} state_t;
    state_t state_reg, state_next;

    logic [SIZE:1]    a_reg, b_reg;
    logic             cin_reg, approx_reg;
    logic [SIZE:1]    sum_reg;
    logic             cout_reg, err_reg;
    logic [CNT_W-1:0] err_cnt_reg;

    logic [NB-1:0]    grp_g, grp_p;
    logic [NB:0]      c_exact;
    logic [NB-1:0]    c_spec;
    logic [SIZE:1]    sum_exact, sum_spec;
    logic             cout_spec, mismatch;
    logic             accept, load_spec, load_exact;

    function automatic logic [1:0] group_gp(input logic [VALENCY-1:0] x, input logic [VALENCY-1:0] y);
        logic gg, pp;
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < VALENCY; i++) begin
            gg = (x[i] & y[i]) | ((x[i] ^ y[i]) & gg);
            pp = pp & (x[i] ^ y[i]);
        end
        return {gg, pp};
    endfunction

    function automatic logic [VALENCY-1:0] block_sum(input logic [VALENCY-1:0] x,
                                                     input logic [VALENCY-1:0] y,
                                                     input logic ci);
        logic               carry;
        logic [VALENCY-1:0] s;
        carry = ci;
        s     = '0;
        for (int i = 0; i < VALENCY; i++) begin
            s[i]  = x[i] ^ y[i] ^ carry;
            carry = (x[i] & y[i]) | ((x[i] ^ y[i]) & carry);
        end
        return s;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_block
            assign {grp_g[gi], grp_p[gi]} = group_gp(a_reg[gi*VALENCY+1 +: VALENCY],
                                                     b_reg[gi*VALENCY+1 +: VALENCY]);
            assign sum_exact[gi*VALENCY+1 +: VALENCY] = block_sum(a_reg[gi*VALENCY+1 +: VALENCY],
                                                                  b_reg[gi*VALENCY+1 +: VALENCY],
                                                                  c_exact[gi]);
            assign sum_spec[gi*VALENCY+1 +: VALENCY]  = block_sum(a_reg[gi*VALENCY+1 +: VALENCY],
                                                                  b_reg[gi*VALENCY+1 +: VALENCY],
                                                                  c_spec[gi]);
        end
    endgenerate

    // Speculative carries only look one block back; block 1 is always exact.
    always_comb begin
        c_exact    = '0;
        c_spec     = '0;
        c_exact[0] = cin_reg;
        for (int k = 0; k < NB; k++) begin
            c_exact[k+1] = grp_g[k] | (grp_p[k] & c_exact[k]);
        end
        c_spec[0] = cin_reg;
        c_spec[1] = c_exact[1];
        for (int k = 1; k < NB - 1; k++) begin
            c_spec[k+1] = grp_g[k];
        end
        cout_spec = grp_g[NB-1] | (grp_p[NB-1] & c_spec[NB-1]);
        mismatch  = (cout_spec != c_exact[NB]);
        for (int k = 2; k < NB; k++) begin
            if (c_spec[k] != c_exact[k]) mismatch = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load_spec  = 1'b0;
        load_exact = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = EVAL;
            end
            EVAL: begin
                load_spec  = 1'b1;
                state_next = (!mismatch || approx_reg) ? HOLD : CORR;
            end
            CORR: begin
                load_exact = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? EVAL : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            cin_reg     <= 1'b0;
            approx_reg  <= 1'b0;
            sum_reg     <= '0;
            cout_reg    <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            if (accept) begin
                a_reg      <= a;
                b_reg      <= b;
                cin_reg    <= cin;
                approx_reg <= approx;
            end
            if (load_spec) begin
                sum_reg  <= sum_spec;
                cout_reg <= cout_spec;
                err_reg  <= mismatch;
                if (mismatch && err_cnt_reg != {CNT_W{1'b1}}) err_cnt_reg <= err_cnt_reg + 1'b1;
            end
            // Correction keeps err set so the consumer still sees the slow path was taken.
            if (load_exact) begin
                sum_reg  <= sum_exact;
                cout_reg <= c_exact[NB];
            end
        end
    end

    assign sum     = sum_reg;
    assign cout    = cout_reg;
    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;
endmodule

// File: tb/tb_variable_latency_cla.sv
// Bench for variable_latency_cla (SIZE=16, VALENCY=4, CNT_W=4): directed cases plus
// random operations checked against an arithmetic model of exact and speculative sums.
module tb_variable_latency_cla;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:1] a = '0;
    logic [16:1] b = '0;
    logic        cin = 1'b0;
    logic        approx = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:1] sum;
    logic        cout;
    logic        err;
    logic [3:0]  err_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  exp_cnt = '0;

    logic [15:0] bb_a [10];
    logic [15:0] bb_b [10];
    logic        bb_c [10];

    variable_latency_cla #(.SIZE(16), .VALENCY(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .approx(approx), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Exact sum is plain addition; speculative block k>=2 takes carry-out of block k-1 with carry-in 0.
    function automatic void model(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                                  input logic xap, output logic [15:0] r_sum, output logic r_co,
                                  output logic r_err, output int r_lat);
        int unsigned ua, ub, uc, ba, bbv, mask, ck, sk, spec_sum, spec_co, exact;
        ua = xa; ub = xb; uc = xc;
        exact = ua + ub + uc;
        spec_sum = 0; spec_co = 0; r_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ba   = (ua >> (4*k)) & 15;
            bbv  = (ub >> (4*k)) & 15;
            mask = (32'd1 << (4*k)) - 1;
            ck   = (((ua & mask) + (ub & mask) + uc) >> (4*k)) & 1;
            if (k == 0)      sk = uc;
            else if (k == 1) sk = ((ua & 15) + (ub & 15) + uc) >> 4;
            else             sk = (((ua >> (4*(k-1))) & 15) + ((ub >> (4*(k-1))) & 15)) >> 4;
            if (k >= 2 && sk != ck) r_err = 1'b1;
            spec_sum += ((ba + bbv + sk) & 15) << (4*k);
            spec_co   = (ba + bbv + sk) >> 4;
        end
        if (spec_co != (exact >> 16)) r_err = 1'b1;
        if (!r_err || xap) begin
            r_sum = 16'(spec_sum); r_co = spec_co[0]; r_lat = 1;
        end else begin
            r_sum = 16'(exact); r_co = exact[16]; r_lat = 2;
        end
    endfunction

    task automatic do_op(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                         input logic xc, input logic xap, input logic [15:0] e_sum,
                         input logic e_co, input logic e_err, input int e_lat, input int hold);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready_idle"}, in_ready, 1);
        a = xa; b = xb; cin = xc; approx = xap; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        // Keep offering junk while busy: it must not replace the accepted operands.
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); approx = 1'($urandom);
        lat = 0;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (e_err && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".sum"}, sum, e_sum);
        check({tag, ".cout"}, cout, e_co);
        check({tag, ".err"}, err, e_err);
        check({tag, ".err_cnt"}, err_cnt, exp_cnt);
        check({tag, ".in_ready_hold"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, out_valid, 1);
            check({tag, ".hold_sum"}, sum, e_sum);
            check({tag, ".hold_cout"}, cout, e_co);
            check({tag, ".hold_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, ".in_ready_follows"}, in_ready, 1);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".released"}, out_valid, 0);
    endtask

    task automatic rand_op(input string tag, input bit want_err, input int hold);
        logic [15:0] ra, rb, ms;
        logic rc, rap, mc, me;
        int ml;
        ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rap = 1'($urandom);
        model(ra, rb, rc, rap, ms, mc, me, ml);
        for (int t = 0; t < 400 && me != want_err; t++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            model(ra, rb, rc, rap, ms, mc, me, ml);
        end
        do_op(tag, ra, rb, rc, rap, ms, mc, me, ml, hold);
    endtask

    initial begin
        logic [15:0] ms;
        logic mc, me;
        int ml;

        #1 rst_n = 1'b0;
        #2;
        check("reset.out_valid", out_valid, 0);
        check("reset.sum", sum, 0);
        check("reset.cout", cout, 0);
        check("reset.err", err, 0);
        check("reset.err_cnt", err_cnt, 0);
        check("reset.in_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("exact_no_err", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1, 0);
        do_op("approx_err", 16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1, 0);
        do_op("corrected", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 2, 0);
        do_op("corr_stall", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 2, 5);
        do_op("approx_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'hFF00, 1'b0, 1'b1, 1, 0);

        for (int i = 0; i < 12; i++) rand_op("random", 1'($urandom), int'($urandom_range(0, 2)));

        // Back-to-back no-error stream: one result every two cycles.
        for (int i = 0; i < 10; i++) begin
            bb_a[i] = 16'($urandom); bb_b[i] = 16'($urandom); bb_c[i] = 1'($urandom);
            model(bb_a[i], bb_b[i], bb_c[i], 1'b0, ms, mc, me, ml);
            for (int t = 0; t < 400 && me; t++) begin
                bb_a[i] = 16'($urandom); bb_b[i] = 16'($urandom);
                model(bb_a[i], bb_b[i], bb_c[i], 1'b0, ms, mc, me, ml);
            end
            if (me) begin
                bb_a[i] = 16'h1234; bb_b[i] = 16'h1111; bb_c[i] = 1'b0;
            end
        end
        @(negedge clk);
        a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; approx = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            model(bb_a[i], bb_b[i], bb_c[i], 1'b0, ms, mc, me, ml);
            @(negedge clk);
            check("b2b.eval_valid", out_valid, 0);
            check("b2b.eval_in_ready", in_ready, 0);
            @(negedge clk);
            check("b2b.valid", out_valid, 1);
            check("b2b.sum", sum, ms);
            check("b2b.cout", cout, mc);
            check("b2b.err", err, 0);
            if (i < 9) begin
                a = bb_a[i+1]; b = bb_b[i+1]; cin = bb_c[i+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b.drained", out_valid, 0);

        // 20 mismatching operations drive the 4-bit counter into saturation.
        for (int i = 0; i < 20; i++) rand_op("saturate", 1'b1, 0);
        check("saturate.final", err_cnt, 4'hF);

        // Reset while the correction cycle is in flight.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; cin = 1'b1; approx = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_reset.in_corr_valid", out_valid, 0);
        check("mid_reset.in_corr_err", err, 1);
        #1 rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        check("mid_reset.out_valid", out_valid, 0);
        check("mid_reset.err_cnt", err_cnt, 0);
        check("mid_reset.err", err, 0);
        check("mid_reset.sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_reset.in_ready", in_ready, 1);
        do_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 2, 1);
        rand_op("after_reset_rand", 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
